spi_initiator: RTL and testbench

Byte-oriented SPI mode-0 initiator: it drives the clock, chip select and outgoing data line that the FPGA-side SPI responder receives. It serves two purposes. It is synthesizable on the iCE40 so that our own logic can drive external SPI peripherals or a loopback to the display-control responder. It is also the bus driver in the top-level simulation benches. Bytes come in on a valid/ready stream, go out MSB-first, and each received byte is returned with a one-cycle strobe.

---
 rtl/spi_initiator.sv | 109 ++++++++++
 tb/tb_spi_initiator.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_initiator.sv
// spi_initiator: byte-stream SPI mode-0 initiator (CPOL=0, CPHA=0), MSB-first,
// with one rx_valid strobe per received byte and cs_n framing over tx_last.
module spi_initiator #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       sck,
  output logic       mosi,
  input  logic       miso,
  output logic       cs_n
);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, WAIT, HOLD, GAP} state_t;
  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d, tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d, rx_data_q, rx_data_d;
  logic [3:0] bit_q, bit_d;
  logic last_q, last_d, sck_q, sck_d, mosi_q, mosi_d, cs_n_q, cs_n_d;
  logic rx_valid_q, rx_valid_d, busy_q;
  logic hs, tick;
  assign tx_ready = !reset && (state_q == IDLE || state_q == WAIT);
  assign hs = tx_valid && tx_ready;
  assign tick = cnt_q == 8'd0;
  assign {rx_data, rx_valid, busy, sck, mosi, cs_n} = {rx_data_q, rx_valid_q, busy_q, sck_q, mosi_q, cs_n_q};
  // The divider free-runs and reloads on every tick, so each state that times
  // a phase sees its next tick exactly CLK_DIV cycles after entry.
  always_comb begin
    state_d = state_q;
    cnt_d = tick ? DIV_M1 : cnt_q - 8'd1;
    tx_sr_d = tx_sr_q;
    rx_sr_d = rx_sr_q;
    rx_data_d = rx_data_q;
    bit_d = bit_q;
    last_d = last_q;
    sck_d = sck_q;
    mosi_d = mosi_q;
    cs_n_d = cs_n_q;
    rx_valid_d = 1'b0;
    case (state_q)
      IDLE, WAIT: if (hs) begin
        state_d = SETUP;
        cnt_d = DIV_M1;
        bit_d = 4'd0;
        tx_sr_d = tx_data;
        last_d = tx_last;
        mosi_d = tx_data[7];
        cs_n_d = 1'b0;
      end
      SETUP, SHIFT: if (tick && !sck_q) begin
        state_d = SHIFT;
        sck_d = 1'b1;
        rx_sr_d = {rx_sr_q[6:0], miso};
        bit_d = bit_q + 4'd1;
      end else if (tick) begin
        sck_d = 1'b0;
        if (bit_q == 4'd8) begin
          rx_data_d = rx_sr_q;
          rx_valid_d = 1'b1;
          state_d = last_q ? HOLD : WAIT;
        end else begin
          tx_sr_d = {tx_sr_q[6:0], 1'b0};
          mosi_d = tx_sr_q[6];
        end
      end
      HOLD: if (tick) begin
        state_d = GAP;
        cs_n_d = 1'b1;
      end
      GAP: if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= 8'd0;
      tx_sr_q <= 8'd0;
      rx_sr_q <= 8'd0;
      rx_data_q <= 8'd0;
      bit_q <= 4'd0;
      last_q <= 1'b0;
      sck_q <= 1'b0;
      mosi_q <= 1'b0;
      cs_n_q <= 1'b1;
      rx_valid_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      tx_sr_q <= tx_sr_d;
      rx_sr_q <= rx_sr_d;
      rx_data_q <= rx_data_d;
      bit_q <= bit_d;
      last_q <= last_d;
      sck_q <= sck_d;
      mosi_q <= mosi_d;
      cs_n_q <= cs_n_d;
      rx_valid_q <= rx_valid_d;
      busy_q <= state_d != IDLE;
    end
  end
endmodule

// File: tb/tb_spi_initiator.sv
// tb_spi_initiator: directed checks of spi_initiator at CLK_DIV=2 (responder model
// or loopback), plus phase-length checks at CLK_DIV=1 and CLK_DIV=255 in loopback.
module tb_spi_initiator;
  logic clk = 1'b0, reset = 1'b1, loop = 1'b0, tx_last = 1'b0;
  logic [7:0] tx_data = 8'h00, resp_byte = 8'h00, mon = 8'h00, b8;
  logic [2:0] v = 3'b000, resp_idx = 3'd0;
  logic [1:0] sel = 2'd0;
  logic tx_ready_a [3], rx_valid_a [3], busy_a [3], sck_a [3], mosi_a [3], miso_a [3], cs_n_a [3];
  logic [7:0] rx_data_a [3];
  logic tx_ready_m, rx_valid_m, busy_m, sck_m, mosi_m, cs_n_m;
  logic [7:0] rx_data_m;
  logic cs_q = 1'b1, rdy_q = 1'b0;
  int cyc = 0, checks = 0, errors = 0;
  int hs_t = 0, hs_cnt = 0, rx_t = 0, rx_gap = 0, rx_cnt = 0, csr_t = 0, cs_rises = 0, rdy_t = 0, rise_cnt = 0;
  int b, h, c, r, bad;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    spi_initiator #(.CLK_DIV(g == 0 ? 2 : g == 1 ? 1 : 255)) u_dut (
      .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(v[g]), .tx_last(tx_last),
      .tx_ready(tx_ready_a[g]), .rx_data(rx_data_a[g]), .rx_valid(rx_valid_a[g]), .busy(busy_a[g]),
      .sck(sck_a[g]), .mosi(mosi_a[g]), .miso(miso_a[g]), .cs_n(cs_n_a[g])
    );
    assign miso_a[g] = (g == 0 && !loop) ? resp_byte[3'd7 - resp_idx] : mosi_a[g];
  end
  assign tx_ready_m = tx_ready_a[sel];
  assign rx_valid_m = rx_valid_a[sel];
  assign rx_data_m = rx_data_a[sel];
  assign busy_m = busy_a[sel];
  assign sck_m = sck_a[sel];
  assign mosi_m = mosi_a[sel];
  assign cs_n_m = cs_n_a[sel];
  // Edge numbers: cyc read at a posedge is that edge's number; at the following negedge it is number+1.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (v[sel] && tx_ready_m) begin
      hs_t <= cyc;
      hs_cnt <= hs_cnt + 1;
    end
  end
  always @(posedge sck_m) begin
    mon <= {mon[6:0], mosi_m};
    rise_cnt <= rise_cnt + 1;
  end
  // Mode-0 responder: bit7 is presented before the first rising edge, the next bit after each rise.
  always @(posedge sck_m or posedge cs_n_m) resp_idx <= cs_n_m ? 3'd0 : resp_idx + 3'd1;
  always @(negedge clk) begin
    if (rx_valid_m) begin
      rx_cnt <= rx_cnt + 1;
      rx_t <= cyc - 1;
      rx_gap <= cyc - 1 - rx_t;
    end
    if (cs_n_m && !cs_q) begin
      cs_rises <= cs_rises + 1;
      csr_t <= cyc - 1;
    end
    if (tx_ready_m && !rdy_q) rdy_t <= cyc - 1;
    cs_q <= cs_n_m;
    rdy_q <= tx_ready_m;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic wait_for(input int which, input int target);
    int n = 0;
    while ((which == 0 ? rx_cnt : which == 1 ? hs_cnt : rise_cnt) < target && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_timeout", 32'(n < 20000), 32'd1);
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy_m && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(n < 20000), 32'd1);
    repeat (2) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] d, input logic l);
    int n = 0;
    while (!tx_ready_m && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", 32'(n < 20000), 32'd1);
    tx_data = d;
    tx_last = l;
    v[sel] = 1'b1;
    @(negedge clk);
    v[sel] = 1'b0;
  endtask
  task automatic phases(input int d);
    int last, n, ph, k;
    logic prev;
    k = rx_cnt;
    send(8'h96, 1'b1);
    last = hs_t;
    prev = 1'b0;
    n = 0;
    ph = 0;
    bad = 0;
    while (ph < 16 && n < 20000) begin
      if (sck_m !== prev) begin
        bad += int'(cyc - 1 - last != d);
        last = cyc - 1;
        prev = sck_m;
        ph++;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    chk("phase_count", ph, 16);
    chk("phase_len_bad", bad, 0);
    wait_for(0, k + 1);
    chk("div_rx_data", rx_data_m, 8'h96);
    chk("div_rx_time", rx_t - hs_t, 16 * d);
    wait_idle();
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tx_ready", tx_ready_m, 1'b0);
    chk("rst_cs_n", cs_n_m, 1'b1);
    chk("rst_sck", sck_m, 1'b0);
    chk("rst_mosi", mosi_m, 1'b0);
    chk("rst_rx_valid", rx_valid_m, 1'b0);
    chk("rst_rx_data", rx_data_m, 8'h00);
    chk("rst_busy", busy_m, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_tx_ready", tx_ready_m, 1'b1);
    // single byte, responder returns 0x3C
    resp_byte = 8'h3C;
    b = rx_cnt;
    r = rise_cnt;
    send(8'hA5, 1'b1);
    chk("t1_busy", busy_m, 1'b1);
    wait_for(0, b + 1);
    chk("t1_rx_data", rx_data_m, 8'h3C);
    chk("t1_rx_time", rx_t - hs_t, 32);
    wait_idle();
    chk("t1_mosi_bits", mon, 8'hA5);
    chk("t1_rises", rise_cnt - r, 8);
    chk("t1_cs_rise", csr_t - hs_t, 34);
    chk("t1_ready_rise", rdy_t - hs_t, 36);
    // three-byte frame, tx_valid held high
    resp_byte = 8'h69;
    b = rx_cnt;
    h = hs_cnt;
    c = cs_rises;
    r = rise_cnt;
    tx_data = 8'h01;
    tx_last = 1'b0;
    v[0] = 1'b1;
    wait_for(1, h + 1);
    tx_data = 8'h80;
    wait_for(1, h + 2);
    tx_data = 8'hFF;
    tx_last = 1'b1;
    wait_for(1, h + 3);
    v[0] = 1'b0;
    chk("t2_gap12", rx_gap, 33);
    wait_for(0, b + 3);
    chk("t2_gap23", rx_gap, 33);
    chk("t2_rx_data", rx_data_m, 8'h69);
    wait_idle();
    chk("t2_cs_rises", cs_rises - c, 1);
    chk("t2_rises", rise_cnt - r, 24);
    chk("t2_handshakes", hs_cnt - h, 3);
    chk("t2_last_mosi", mon, 8'hFF);
    // stalled frame
    resp_byte = 8'hC6;
    b = rx_cnt;
    c = cs_rises;
    send(8'h11, 1'b0);
    wait_for(0, b + 1);
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      bad += int'(cs_n_m !== 1'b0 || sck_m !== 1'b0 || tx_ready_m !== 1'b1);
    end
    chk("t3_wait_bad", bad, 0);
    send(8'h22, 1'b1);
    wait_for(0, b + 2);
    chk("t3_rx_data", rx_data_m, 8'hC6);
    wait_idle();
    chk("t3_cs_rises", cs_rises - c, 1);
    chk("t3_mosi_bits", mon, 8'h22);
    // reset after the 4th rising sck edge
    b = rx_cnt;
    r = rise_cnt;
    send(8'hF0, 1'b1);
    wait_for(2, r + 4);
    chk("t4_mosi_before", mosi_m, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("t4_cs_n", cs_n_m, 1'b1);
    chk("t4_sck", sck_m, 1'b0);
    chk("t4_mosi", mosi_m, 1'b0);
    chk("t4_busy", busy_m, 1'b0);
    chk("t4_ready_in_reset", tx_ready_m, 1'b0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("t4_no_rx_valid", rx_cnt - b, 0);
    resp_byte = 8'hB4;
    send(8'h5A, 1'b1);
    wait_for(0, b + 1);
    chk("t4_fresh_rx", rx_data_m, 8'hB4);
    wait_idle();
    chk("t4_fresh_mosi", mon, 8'h5A);
    // inputs toggled while busy
    resp_byte = 8'h0F;
    h = hs_cnt;
    send(8'hC3, 1'b1);
    repeat (20) begin
      b8 = 8'($urandom);
      tx_data = b8;
      tx_last = b8[0];
      v[0] = b8[7];
      @(negedge clk);
    end
    v[0] = 1'b0;
    wait_idle();
    chk("t5_handshakes", hs_cnt - h, 1);
    chk("t5_mosi_bits", mon, 8'hC3);
    chk("t5_rx_data", rx_data_m, 8'h0F);
    // divider extremes, loopback
    sel = 2'd1;
    phases(1);
    sel = 2'd2;
    phases(255);
    // loopback, 256 random bytes in one frame
    sel = 2'd0;
    loop = 1'b1;
    b = rx_cnt;
    for (int i = 0; i < 256; i++) begin
      b8 = 8'($urandom_range(0, 255));
      send(b8, i == 255);
      wait_for(0, b + i + 1);
      chk("loopback", rx_data_m, b8);
    end
    wait_idle();
    chk("loop_rx_count", rx_cnt - b, 256);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
